multiband_eq_engine: RTL
========================

Name: multiband_eq_engine

Overview:
- Time-multiplexed N-band biquad equaliser for stereo I2S audio.
- A single shared multiply-accumulate unit runs every band for the current channel on each l_r_clk edge.
- Run-time mode selects cascade (serial bands) or parallel (per-band gain-weighted sum).
- Replaces three separate per-band filter instances plus glue; sits between I2S receiver and transmitter.

Parameters:
NUM_BANDS, 3, number of biquad sections (1..8)
DATA_W, 16, audio sample width, signed
COEF_W, 16, coefficient/gain width, signed
COEF_FRAC, 14, fractional bits of coefficients and gains (Q2.14 default)
ACC_W, 40, accumulator width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
l_r_clk  in  1  I2S word select; every edge marks a new sample; level after edge = channel (0 left, 1 right)
audio_in  in  DATA_W  signed input sample, valid at l_r_clk edge
coefs  in  NUM_BANDS*5*COEF_W  band b, tap k at [(5b+k)*COEF_W +: COEF_W], k order b0,b1,b2,a1,a2
band_gain  in  NUM_BANDS*COEF_W  per-band gain, Q-format as coefs, parallel mode only
mode  in  1  0 cascade, 1 parallel
bypass  in  1  1: output raw input, filters keep running
audio_out  out  DATA_W  signed result, held between updates
out_valid  out  1  one-cycle pulse when audio_out updates
busy  out  1  high from capture to out_valid inclusive
overrun  out  1  sticky: edge arrived while busy

Behaviour:
- Reset: all band/channel states (x1,x2,y1,y2) = 0, audio_out=0, out_valid=0, busy=0, overrun=0, FSM IDLE. Reset mid-computation aborts: no out_valid. During reset, l_r_clk_prev loads l_r_clk, so no spurious edge on release.
- Edge detect: l_r_clk != l_r_clk_prev while IDLE → CAPTURE cycle (cycle 0). Latch audio_in, channel=l_r_clk, mode, bypass.
- FSM: IDLE → CAPTURE → per band: MAC×5 (taps b0·x, b1·x1, b2·x2, −a1·y1, −a2·y2) → WRITE → next band or (mode=1) SUM×NUM_BANDS → SUMWR, then OUTPUT → IDLE.
- Band math: y = b0x + b1x1 + b2x2 − a1y1 − a2y2 in ACC_W. Result = (acc + 2^(COEF_FRAC−1)) >>> COEF_FRAC, saturated to DATA_W.
- WRITE updates that channel/band state: x2←x1, x1←x, y2←y1, y1←y (saturated y).
- Cascade: band 0 input = captured sample; band b input = band b−1 saturated output. Final band output is the result.
- Parallel: every band input = captured sample. SUM accumulates gain_b·y_b, then rounds/saturates as above.
- OUTPUT: audio_out ← result (or captured sample if bypass). out_valid=1 for this cycle only.
- Latency (cycle 0 = CAPTURE): out_valid at cycle 1+6·NUM_BANDS (cascade) or 2+7·NUM_BANDS (parallel). NUM_BANDS=3 gives 19 / 23.
- Edge seen while busy: sample dropped, overrun←1 (cleared only by reset), current computation unaffected.
- Coefs/gains sampled live during MAC; software changes them only between samples. mode/bypass changes take effect at next CAPTURE.
- Channels fully independent: left state never touched by right samples.

Decomposition:
- Package eq_pkg: FSM state enum, tap index enum (TAP_B0..TAP_A2), round constant, saturate function.
- Sub-module eq_mac: signed multiply, accumulate, clear, and round/saturate output. One instance.
- State storage: register array [2][NUM_BANDS][4].

Test Plan:
1. Cascade, all bands b0=16384 (others 0), left input 1000 → audio_out=1000, single out_valid at cycle 19.
2. Band0 b1=16384 only (bands 1,2 identity); left 100,200 interleaved with right 7,8 → left outputs 0,100; right outputs 0,7.
3. Band0 b0=32767, bands 1,2 identity; input 30000 → 32767; input −30000 → −32768.
4. Parallel, identity bands, gains 8192 each (NUM_BANDS=3); input 1000 → 1500, out_valid at cycle 23.
5. Band0 b0=16384, a1=−8192 (others identity); left impulse 1000 then zeros → 1000, 500, 250, 125.
6. Second edge 3 clocks after first → overrun=1, one out_valid only. Reset asserted at cycle 10 → audio_out=0, no out_valid, busy=0.

Source files
------------

// File: rtl/eq_pkg.sv
// eq_pkg: shared FSM/tap enums and fixed-point rounding helpers for the band equaliser
package eq_pkg;
  typedef enum logic [2:0] {IDLE, CAPTURE, MAC, WRITE, SUM, SUMWR, OUTPUT} state_t;
  typedef enum logic [2:0] {TAP_B0, TAP_B1, TAP_B2, TAP_A1, TAP_A2} tap_t;
  function automatic logic signed [63:0] round_const(input int frac);
    return 64'sd1 <<< (frac - 1);
  endfunction
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return v > hi ? hi : v < lo ? lo : v;
  endfunction
endpackage

// File: rtl/eq_mac.sv
// eq_mac: shared signed multiply-accumulate with rounded, saturated output
module eq_mac import eq_pkg::*; #(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int COEF_FRAC = 14,
  parameter int ACC_W     = 40
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     clear,
  input  logic                     sub,
  input  logic signed [COEF_W-1:0] coef,
  input  logic signed [DATA_W-1:0] data,
  output logic signed [DATA_W-1:0] result
);
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] prod;
  logic signed [ACC_W-1:0] base;
  logic signed [63:0] rounded;
  always_comb begin
    prod = ACC_W'(coef) * ACC_W'(data);
    base = clear ? '0 : acc;
    rounded = (64'(acc) + round_const(COEF_FRAC)) >>> COEF_FRAC;
    result = DATA_W'(saturate(rounded, DATA_W));
  end
  always_ff @(posedge clk)
    if (reset) acc <= '0;
    else if (en) acc <= sub ? base - prod : base + prod;
endmodule

// File: rtl/multiband_eq_engine.sv
// multiband_eq_engine: time-multiplexed stereo biquad equaliser, cascade or gain-weighted parallel bands
module multiband_eq_engine import eq_pkg::*; #(
  parameter int NUM_BANDS = 3,
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int COEF_FRAC = 14,
  parameter int ACC_W     = 40
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             l_r_clk,
  input  logic signed [DATA_W-1:0]         audio_in,
  input  logic [NUM_BANDS*5*COEF_W-1:0]    coefs,
  input  logic [NUM_BANDS*COEF_W-1:0]      band_gain,
  input  logic                             mode,
  input  logic                             bypass,
  output logic signed [DATA_W-1:0]         audio_out,
  output logic                             out_valid,
  output logic                             busy,
  output logic                             overrun
);
  localparam int BW = NUM_BANDS > 1 ? $clog2(NUM_BANDS) : 1;
  localparam logic [BW-1:0] LAST = BW'(NUM_BANDS - 1);
  state_t state, next_state;
  tap_t tap;
  logic [BW-1:0] band;
  logic ch, mode_l, bypass_l, lr_prev, lr_edge, last_band;
  logic mac_en, mac_clear, mac_sub;
  logic signed [DATA_W-1:0] sample, x_cur, mac_y, mac_data;
  logic signed [COEF_W-1:0] mac_coef;
  // per channel/band history: 0=x1 1=x2 2=y1 3=y2
  logic signed [DATA_W-1:0] st [2][NUM_BANDS][4];
  always_comb begin
    lr_edge = l_r_clk != lr_prev;
    last_band = band == LAST;
    mac_en = state == MAC || state == SUM;
    mac_clear = (state == MAC && tap == TAP_B0) || (state == SUM && band == '0);
    mac_sub = state == MAC && (tap == TAP_A1 || tap == TAP_A2);
    mac_coef = state == SUM ? band_gain[int'(band)*COEF_W +: COEF_W]
                            : coefs[(5*int'(band) + int'(tap))*COEF_W +: COEF_W];
    mac_data = state == SUM    ? st[ch][band][2] :
               tap == TAP_B0   ? x_cur :
               tap == TAP_B1   ? st[ch][band][0] :
               tap == TAP_B2   ? st[ch][band][1] :
               tap == TAP_A1   ? st[ch][band][2] : st[ch][band][3];
  end
  eq_mac #(.DATA_W(DATA_W), .COEF_W(COEF_W), .COEF_FRAC(COEF_FRAC), .ACC_W(ACC_W)) u_mac (
    .clk(clk), .reset(reset), .en(mac_en), .clear(mac_clear), .sub(mac_sub),
    .coef(mac_coef), .data(mac_data), .result(mac_y)
  );
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= next_state;
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = lr_edge ? CAPTURE : IDLE;
      CAPTURE: next_state = MAC;
      MAC:     next_state = tap == TAP_A2 ? WRITE : MAC;
      WRITE:   next_state = !last_band ? MAC : mode_l ? SUM : OUTPUT;
      SUM:     next_state = last_band ? SUMWR : SUM;
      SUMWR:   next_state = OUTPUT;
      OUTPUT:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end
  always_comb begin
    busy = state != IDLE;
    out_valid = state == OUTPUT;
  end
  always_ff @(posedge clk) begin
    lr_prev <= l_r_clk;
    if (reset) begin
      overrun <= 1'b0;
      audio_out <= '0;
      tap <= TAP_B0;
      band <= '0;
      ch <= 1'b0;
      mode_l <= 1'b0;
      bypass_l <= 1'b0;
      sample <= '0;
      x_cur <= '0;
      for (int c = 0; c < 2; c++)
        for (int b = 0; b < NUM_BANDS; b++)
          for (int k = 0; k < 4; k++)
            st[c][b][k] <= '0;
    end else begin
      if (lr_edge && state != IDLE) overrun <= 1'b1;
      if (lr_edge && state == IDLE) begin
        sample <= audio_in;
        x_cur <= audio_in;
        ch <= l_r_clk;
        mode_l <= mode;
        bypass_l <= bypass;
        band <= '0;
        tap <= TAP_B0;
      end
      if (state == MAC) tap <= tap.next();
      if (state == WRITE) begin
        st[ch][band][0] <= x_cur;
        st[ch][band][1] <= st[ch][band][0];
        st[ch][band][2] <= mac_y;
        st[ch][band][3] <= st[ch][band][2];
        x_cur <= mode_l ? sample : mac_y;
      end
      if (state == WRITE || state == SUM) band <= last_band ? '0 : band + 1'b1;
      if ((state == WRITE && last_band && !mode_l) || state == SUMWR)
        audio_out <= bypass_l ? sample : mac_y;
    end
  end
endmodule
